genius_sequence_game: RTL and testbench

//  Single-player memory game (Genius/Simon). A sequence of one-hot button plays is stored in a 16x4 RAM.

---
 rtl/genius_sequence_game_pkg.sv | 30 +++
 rtl/genius_sequence_game_hex7seg.sv | 28 ++
 rtl/genius_sequence_game.sv | 151 +++++++++++++++
 tb/tb_genius_sequence_game.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/genius_sequence_game_pkg.sv
// Shared definitions for the Genius memory game: state codes, timing defaults, fixed first play.
package genius_sequence_game_pkg;

  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    EXIBE          = 4'h2,
    ESPERA         = 4'h3,
    REGISTRA       = 4'h4,
    COMPARA        = 4'h5,
    PROXIMA        = 4'h6,
    ESPERA_ADD     = 4'h7,
    REGISTRA_ADD   = 4'h8,
    ESCREVE        = 4'h9,
    AUMENTA_LIMITE = 4'hA,
    FIM_ACERTO     = 4'hB,
    FIM_ERRO       = 4'hC,
    FIM_TIMEOUT    = 4'hD
  } estado_t;

  localparam int EXIBE_CICLOS_DEF   = 2000;
  localparam int TIMEOUT_CICLOS_DEF = 5000;
  localparam int TIMER_W            = 13;
  localparam logic [3:0] PRIMEIRA_JOGADA = 4'b0001;

  function automatic logic is_final(estado_t e);
    return (e == FIM_ACERTO) || (e == FIM_ERRO) || (e == FIM_TIMEOUT);
  endfunction

endpackage

// File: rtl/genius_sequence_game_hex7seg.sv
// 4-bit value to active-low gfedcba 7-segment pattern; purely combinational.
module hex7seg (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    case (hex_i)
      4'h0: seg_o = 7'b1000000;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      default: seg_o = 7'b0001110;
    endcase
  end

endmodule

// File: rtl/genius_sequence_game.sv
// Genius/Simon game: datapath (address/limit counters, 16x4 play RAM, shared timer) plus control FSM.
// A play takes effect a few cycles after the press edge; buttons are only sampled while waiting (states 3/7).
module genius_sequence_game
  import genius_sequence_game_pkg::*;
#(
  parameter int EXIBE_CICLOS   = EXIBE_CICLOS_DEF,
  parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic [3:0] botoes,
  input  logic [1:0] configuracao,
  output logic       ganhou,
  output logic       perdeu,
  output logic       pronto,
  output logic [2:0] leds,
  output logic       timeout,
  output logic       db_igual,
  output logic [6:0] db_contagem,
  output logic [6:0] db_memoria,
  output logic [6:0] db_estado,
  output logic [6:0] db_jogadafeita,
  output logic       db_clock,
  output logic       db_iniciar,
  output logic       db_tem_jogada,
  output logic       db_timeout,
  output logic       db_fimRodada,
  output logic       db_zeraCL
);

  estado_t              estado_q, estado_d;
  logic [3:0]           endereco_q, limite_q, jogada_q, botoes_prev_q;
  logic [1:0]           cfg_q;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [3:0]           ram_q [0:15];

  logic [3:0] mem_rd, max_lim;
  logic       tem_jogada, igual, fim_rodada, exibe_fim, timeout_fim;
  logic       zera_cl, conta_e, ld_jog, ld_add, escreve, conta_lim, ld_cfg;

  assign mem_rd      = (endereco_q == 4'd0) ? PRIMEIRA_JOGADA : ram_q[endereco_q];
  assign igual       = (jogada_q == mem_rd);
  assign fim_rodada  = (endereco_q == limite_q);
  assign max_lim     = cfg_q[0] ? 4'd3 : 4'd15;
  assign tem_jogada  = (botoes != 4'd0) && (botoes_prev_q == 4'd0);
  assign exibe_fim   = (timer_q == TIMER_W'(EXIBE_CICLOS - 1));
  assign timeout_fim = (timer_q == TIMER_W'(TIMEOUT_CICLOS - 1));

  // Any state change restarts the shared timer, so 2/3/7 each begin counting from zero.
  assign timer_d = (estado_d != estado_q) ? '0 : timer_q + 1'b1;

  always_ff @(posedge clock) begin
    if (!reset) estado_q <= INICIAL;
    else        estado_q <= estado_d;
  end

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      INICIAL:        if (jogar) estado_d = PREPARACAO;
      PREPARACAO:     estado_d = EXIBE;
      EXIBE:          if (exibe_fim) estado_d = ESPERA;
      ESPERA: begin
        if (tem_jogada)                  estado_d = REGISTRA;
        else if (timeout_fim && cfg_q[1]) estado_d = FIM_TIMEOUT;
      end
      REGISTRA:       estado_d = COMPARA;
      COMPARA: begin
        if (!igual)                                estado_d = FIM_ERRO;
        else if (fim_rodada && limite_q == max_lim) estado_d = FIM_ACERTO;
        else if (fim_rodada)                       estado_d = ESPERA_ADD;
        else                                       estado_d = PROXIMA;
      end
      PROXIMA:        estado_d = ESPERA;
      ESPERA_ADD: begin
        if (tem_jogada)                  estado_d = REGISTRA_ADD;
        else if (timeout_fim && cfg_q[1]) estado_d = FIM_TIMEOUT;
      end
      REGISTRA_ADD:   estado_d = ESCREVE;
      ESCREVE:        estado_d = AUMENTA_LIMITE;
      AUMENTA_LIMITE: estado_d = ESPERA;
      FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: if (jogar) estado_d = PREPARACAO;
      default:        estado_d = INICIAL;
    endcase
  end

  always_comb begin
    zera_cl   = (estado_q == PREPARACAO);
    conta_e   = (estado_q == PROXIMA);
    ld_jog    = (estado_q == REGISTRA);
    ld_add    = (estado_q == REGISTRA_ADD);
    escreve   = (estado_q == ESCREVE);
    conta_lim = (estado_q == AUMENTA_LIMITE);
    ld_cfg    = jogar && ((estado_q == INICIAL) || is_final(estado_q));
    leds      = {estado_q == EXIBE, estado_q == ESPERA_ADD, estado_q == ESPERA};
    ganhou    = (estado_q == FIM_ACERTO);
    perdeu    = (estado_q == FIM_ERRO) || (estado_q == FIM_TIMEOUT);
    timeout   = (estado_q == FIM_TIMEOUT);
    pronto    = is_final(estado_q);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      endereco_q    <= '0;
      limite_q      <= '0;
      jogada_q      <= '0;
      cfg_q         <= '0;
      timer_q       <= '0;
      botoes_prev_q <= '0;
    end else begin
      botoes_prev_q <= botoes;
      timer_q       <= timer_d;
      if (ld_cfg) cfg_q <= configuracao;
      if (zera_cl) begin
        endereco_q <= '0;
        limite_q   <= '0;
        jogada_q   <= '0;
      end
      if (conta_e) endereco_q <= endereco_q + 4'd1;
      if (ld_jog)  jogada_q   <= botoes;
      if (ld_add) begin
        jogada_q   <= botoes;
        endereco_q <= limite_q + 4'd1;
      end
      if (conta_lim) begin
        limite_q   <= limite_q + 4'd1;
        endereco_q <= '0;
      end
    end
  end

  // Play memory is deliberately not reset; address 0 is never written.
  always_ff @(posedge clock) begin
    if (escreve) ram_q[endereco_q] <= jogada_q;
  end

  hex7seg u_seg_cont (.hex_i(endereco_q), .seg_o(db_contagem));
  hex7seg u_seg_mem  (.hex_i(mem_rd),     .seg_o(db_memoria));
  hex7seg u_seg_est  (.hex_i(estado_q),   .seg_o(db_estado));
  hex7seg u_seg_jog  (.hex_i(jogada_q),   .seg_o(db_jogadafeita));

  assign db_igual      = igual;
  assign db_clock      = clock;
  assign db_iniciar    = jogar;
  assign db_tem_jogada = tem_jogada;
  assign db_timeout    = timeout_fim;
  assign db_fimRodada  = fim_rodada;
  assign db_zeraCL     = zera_cl;

endmodule

// File: tb/tb_genius_sequence_game.sv
// Bench for genius_sequence_game: table-driven play sequences checked through a scoreboard queue.
module tb_genius_sequence_game;

  logic       clock = 1'b0;
  logic       reset, jogar;
  logic [3:0] botoes;
  logic [1:0] configuracao;
  logic       ganhou, perdeu, pronto, timeout;
  logic [2:0] leds;
  logic       db_igual, db_clock, db_iniciar, db_tem_jogada, db_timeout, db_fimRodada, db_zeraCL;
  logic [6:0] db_contagem, db_memoria, db_estado, db_jogadafeita;

  always #5 clock = ~clock;

  genius_sequence_game dut (
    .clock(clock), .reset(reset), .jogar(jogar), .botoes(botoes), .configuracao(configuracao),
    .ganhou(ganhou), .perdeu(perdeu), .pronto(pronto), .leds(leds), .timeout(timeout),
    .db_igual(db_igual), .db_contagem(db_contagem), .db_memoria(db_memoria),
    .db_estado(db_estado), .db_jogadafeita(db_jogadafeita), .db_clock(db_clock),
    .db_iniciar(db_iniciar), .db_tem_jogada(db_tem_jogada), .db_timeout(db_timeout),
    .db_fimRodada(db_fimRodada), .db_zeraCL(db_zeraCL)
  );

  // Observed outputs packed as {leds[2:0], ganhou, perdeu, pronto, timeout}
  localparam logic [6:0] O_IDLE   = 7'b000_0000;
  localparam logic [6:0] O_ESPERA = 7'b001_0000;
  localparam logic [6:0] O_ADD    = 7'b010_0000;
  localparam logic [6:0] O_WIN    = 7'b000_1010;
  localparam logic [6:0] O_LOSE   = 7'b000_0110;
  localparam logic [6:0] O_TO     = 7'b000_0111;

  localparam logic [6:0] SEG0 = 7'b1000000;
  localparam logic [6:0] SEG1 = 7'b1111001;
  localparam logic [6:0] SEGB = 7'b0000011;
  localparam logic [6:0] SEGC = 7'b1000110;
  localparam logic [6:0] SEGD = 7'b0100001;

  typedef struct {
    logic [3:0] btn;
    logic [6:0] exp;
  } step_t;

  step_t      win_tab [13];
  logic [6:0] sb_q [$];
  int         n_tests = 0;
  int         n_fail  = 0;

  function automatic logic [6:0] obs();
    return {leds, ganhou, perdeu, pronto, timeout};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Hold a button for `hold` cycles, release, and let the FSM settle.
  task automatic press(input logic [3:0] b, input int hold, output int pulses);
    @(negedge clock);
    botoes = b;
    pulses = 0;
    for (int i = 0; i < hold; i++) begin
      #1;
      if (db_tem_jogada) pulses++;
      @(negedge clock);
    end
    botoes = 4'd0;
    repeat (4) @(negedge clock);
  endtask

  task automatic play(input step_t s, input string name);
    int p;
    logic [6:0] e;
    sb_q.push_back(s.exp);
    press(s.btn, 3, p);
    if (sb_q.size() == 0) begin
      check({name, "_sb_empty"}, 1, 0);
    end else begin
      e = sb_q.pop_front();
      check(name, obs(), e);
    end
  endtask

  task automatic start_game(input logic [1:0] cfg, input string name);
    int hi = 0;
    @(negedge clock);
    configuracao = cfg;
    jogar = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (i == 4) jogar = 1'b0;
      if (leds[2]) hi++;
      else if (hi > 0) break;
    end
    jogar = 1'b0;
    check({name, "_exibe_len"}, hi, 2000);
    check({name, "_after_exibe"}, obs(), O_ESPERA);
  endtask

  initial begin
    int p, cnt;
    win_tab = '{
      '{4'b0001, O_ADD},    '{4'b0010, O_ESPERA},
      '{4'b0001, O_ESPERA}, '{4'b0010, O_ADD},    '{4'b0100, O_ESPERA},
      '{4'b0001, O_ESPERA}, '{4'b0010, O_ESPERA}, '{4'b0100, O_ADD},    '{4'b1000, O_ESPERA},
      '{4'b0001, O_ESPERA}, '{4'b0010, O_ESPERA}, '{4'b0100, O_ESPERA}, '{4'b1000, O_WIN}
    };

    reset = 1'b0; jogar = 1'b0; botoes = 4'd0; configuracao = 2'b00;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_outputs", obs(), O_IDLE);
    check("reset_estado", db_estado, SEG0);
    check("reset_zeraCL_tem", {db_zeraCL, db_tem_jogada}, 2'b00);
    reset = 1'b1;
    repeat (10) @(negedge clock);
    check("idle_estado", db_estado, SEG0);
    check("idle_outputs", obs(), O_IDLE);

    // Full demo game won
    start_game(2'b01, "win");
    for (int i = 0; i < 13; i++) play(win_tab[i], $sformatf("win_step%0d", i));
    check("win_estado", db_estado, SEGB);

    // Restart from a final state, then a wrong first play
    start_game(2'b01, "lose");
    play('{4'b0100, O_LOSE}, "lose_wrong");
    check("lose_estado", db_estado, SEGC);

    // Timeout enabled: exactly TIMEOUT_CICLOS waiting cycles
    start_game(2'b11, "to");
    cnt = 0;
    for (int i = 0; i < 6000; i++) begin
      if (!leds[0]) break;
      cnt++;
      @(negedge clock);
    end
    check("to_wait_len", cnt, 5000);
    check("to_outputs", obs(), O_TO);
    check("to_estado", db_estado, SEGD);

    // Timeout disabled: keeps waiting
    start_game(2'b01, "noto");
    repeat (6000) @(negedge clock);
    check("noto_waiting", obs(), O_ESPERA);

    // Held button gives one play and one address step
    play('{4'b0001, O_ADD}, "hold_r1a");
    play('{4'b0010, O_ESPERA}, "hold_r1b");
    press(4'b0001, 20, p);
    check("hold_pulses", p, 1);
    check("hold_outputs", obs(), O_ESPERA);
    check("hold_endereco", db_contagem, SEG1);

    // Mid-round reset
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("midreset_estado", db_estado, SEG0);
    check("midreset_outputs", obs(), O_IDLE);
    reset = 1'b1;
    repeat (10) @(negedge clock);
    check("midreset_idle", db_estado, SEG0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
